uart_frame_parser: RTL and testbench
====================================

Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream over a valid/ready handshake.
- Delineates framed commands of the form SOF(0xA5), LEN, PAYLOAD[LEN], CHK, and verifies length and checksum.
- Buffers the payload and presents each good frame to the register/command block as a length plus a random-read buffer.
- Drops bad frames, pulses an error flag, and re-hunts for the next SOF.

Parameters:
- MAX_LEN, 16: maximum payload bytes accepted; sets buffer depth (2..255).
- LEN_W, 5: width of frame_len and rd_addr; must satisfy 2^LEN_W > MAX_LEN.
- TIMEOUT_CYCLES, 500000: inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  8  received byte from UART receiver
- in_valid  in  1  in_data valid
- in_ready  out  1  parser can accept a byte
- frame_valid  out  1  complete, checked frame available
- frame_ready  in  1  consumer releases the frame
- frame_len  out  LEN_W  payload length of the presented frame
- rd_addr  in  LEN_W  payload byte index for reading
- rd_data  out  8  payload byte at rd_addr (combinational read)
- chk_err  out  1  one-cycle pulse: checksum mismatch
- len_err  out  1  one-cycle pulse: LEN > MAX_LEN
- tmo_err  out  1  one-cycle pulse: inter-byte timeout (0 when feature is off)

Behaviour:
- Reset values: state=HUNT, frame_valid=0, frame_len=0, all err pulses=0, checksum accumulator=0, byte index=0. in_ready=1 in HUNT, including while reset is asserted.
- Byte acceptance: a byte is accepted on a posedge with in_valid && in_ready. Every state transition below occurs on that edge, except in DONE.
- in_ready = (state != DONE), decoded combinationally from state. This back-pressures the receiver while a frame is held.
- HUNT:
  - 0xA5 -> LEN.
  - Any other byte is discarded silently.
- LEN:
  - Store len and chk_acc = byte.
  - len > MAX_LEN -> len_err pulse next cycle, go to HUNT.
  - len == 0 -> CHK.
  - Otherwise idx=0 -> PAYLOAD.
- PAYLOAD:
  - buf[idx] <= byte; chk_acc ^= byte; idx++.
  - After the byte with idx == len-1 -> CHK.
  - 0xA5 inside the payload is ordinary data; there is no resync.
- CHK:
  - byte == chk_acc -> frame_len <= len, frame_valid <= 1 on the next clock, go to DONE.
  - Mismatch -> chk_err pulse, go to HUNT; the buffer contents are don't-care.
- DONE:
  - frame_valid held high and buf is stable.
  - On frame_valid && frame_ready, frame_valid goes to 0 and state goes to HUNT on the next cycle; in_ready rises the same cycle.
- Latency: frame_valid is high exactly 1 cycle after the CHK byte is accepted.
- Checksum: 8-bit XOR of LEN and all payload bytes. SOF is excluded.
- rd_data = buf[rd_addr].
  - Valid only while frame_valid=1 and rd_addr < frame_len.
  - For other addresses the data is undefined, but the read must not be X-propagating in simulation: return 0 when rd_addr >= MAX_LEN.
- Simultaneous events: an error pulse and a new byte in the same cycle is legal. The byte on the edge of the error transition has already been consumed by the old state, so it is not reinterpreted as SOF.
- Reset mid-frame: all state returns to reset values immediately; a partial frame is lost.

Optional Feature:
- Macro: UART_FRAME_PARSER_TIMEOUT_EN.
- With the macro:
  - 32-bit counter, cleared on every accepted byte and in HUNT/DONE; increments in LEN/PAYLOAD/CHK.
  - When it reaches TIMEOUT_CYCLES-1: tmo_err pulse, state -> HUNT, counter cleared.
  - If a byte is accepted on the same edge, the byte wins and there is no timeout.
- Without the macro: no counter is synthesised, tmo_err is tied to 0, and a stalled frame waits indefinitely.

Decomposition:
- Shared package uart_pkg:
  - UART_SOF = 8'hA5.
  - Parser state encodings HUNT/LEN/PAYLOAD/CHK/DONE (3-bit).
  - Checksum function (8-bit XOR step).
- One natural sub-module, uart_frame_buf: MAX_LEN x 8 register array with a synchronous write port and a combinational read port. The parser FSM, checksum and timeout stay in uart_frame_parser.

Test Plan:
- Good frame: A5 03 11 22 33 00 (chk = 03^11^22^33 = 0x03)
  - Correct CHK byte: send A5 03 11 22 33 03 -> frame_valid 1 cycle after the last byte; frame_len=3; rd_addr 0..2 -> 11,22,33.
  - Wrong CHK byte: send A5 03 11 22 33 00 -> chk_err single pulse, no frame_valid; next frame A5 00 00 is accepted (len 0).
- Back-pressure: hold frame_ready=0 for 100 cycles after a good frame -> in_ready=0 throughout, further input is not consumed; frame_ready=1 -> frame_valid falls and in_ready rises the next cycle.
- Garbage then frame: 00 FF 5A A5 02 A5 A5 00 -> payload A5,A5 accepted as data, chk 02^A5^A5=02 mismatch (00) -> chk_err. Retest with chk 02 -> frame_len=2.
- Length overflow: A5 11 (17 > MAX_LEN=16) -> len_err pulse, parser in HUNT; the following A5 01 7E 7F yields a good frame, rd_data[0]=7E.
- Timeout (macro on, TIMEOUT_CYCLES=100): A5 04 AA then silence -> tmo_err at cycle 100 after AA; a subsequent good frame is accepted. Macro off: no tmo_err, and resuming the bytes completes the frame.
- Reset mid-frame: rst_n low after A5 04 AA -> outputs at reset values; A5 01 55 54 afterwards gives a good frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command-frame path: SOF marker, parser
// state encodings and the running-checksum step.
package uart_pkg;

  localparam logic [7:0] UART_SOF = 8'hA5;

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CHK     = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 register array, synchronous write and
// combinational read that returns 0 for addresses outside the array.
module uart_frame_buf
  import uart_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [LEN_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [LEN_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  logic [7:0] mem_r [MAX_LEN];

  // Payload storage; cleared on reset so reads never return X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (wr_en && (wr_addr == LEN_W'(i))) begin
          mem_r[i] <= wr_data;
        end
      end
    end
  end

  // Decoded read mux; an address with no matching entry yields 0.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (rd_addr == LEN_W'(i)) begin
        rd_data = mem_r[i];
      end else begin
        rd_data = rd_data;
      end
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame delineator for SOF/LEN/PAYLOAD/CHK commands from the UART receiver.
// Optional inter-byte timeout enabled by defining UART_FRAME_PARSER_TIMEOUT_EN.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int LEN_W          = 5,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [LEN_W-1:0] frame_len,
  input  logic [LEN_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             chk_err,
  output logic             len_err,
  output logic             tmo_err
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  generate
    if ((MAX_LEN < 2) || (MAX_LEN > 255) || ((1 << LEN_W) <= MAX_LEN) || (TIMEOUT_CYCLES < 2)) begin : g_cfg_err
      $error("uart_frame_parser: illegal MAX_LEN/LEN_W/TIMEOUT_CYCLES combination");
    end
  endgenerate

  logic [2:0]       state_r;
  logic [7:0]       len_r;
  logic [7:0]       chk_acc_r;
  logic [LEN_W-1:0] idx_r;
  logic [LEN_W-1:0] last_idx_s;
  logic             accept_s;
  logic             buf_we_s;
  logic             tmo_hit_s;

  assign in_ready   = (state_r != ST_DONE);
  assign accept_s   = in_valid && in_ready;
  assign buf_we_s   = accept_s && (state_r == ST_PAYLOAD);
  assign last_idx_s = LEN_W'(len_r - 8'd1);

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
  logic [31:0] tmo_cnt_r;
  logic        busy_s;

  assign busy_s    = (state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CHK);
  // An accepted byte on the expiry edge wins over the timeout.
  assign tmo_hit_s = busy_s && !accept_s && (tmo_cnt_r == 32'(TIMEOUT_CYCLES - 1));

  // Inter-byte idle counter, only running while a frame is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= 32'd0;
    end else if (!busy_s || accept_s || tmo_hit_s) begin
      tmo_cnt_r <= 32'd0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Frame FSM, checksum accumulation and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_HUNT;
      len_r       <= 8'd0;
      chk_acc_r   <= 8'd0;
      idx_r       <= '0;
      frame_valid <= 1'b0;
      frame_len   <= '0;
      chk_err     <= 1'b0;
      len_err     <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      chk_err <= 1'b0;
      len_err <= 1'b0;
      tmo_err <= tmo_hit_s;
      case (state_r)
        ST_HUNT: begin
          if (accept_s && (in_data == UART_SOF)) begin
            state_r <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (accept_s) begin
            len_r     <= in_data;
            chk_acc_r <= in_data;
            if (in_data > MAX_LEN_B) begin
              len_err <= 1'b1;
              state_r <= ST_HUNT;
            end else if (in_data == 8'd0) begin
              state_r <= ST_CHK;
            end else begin
              idx_r   <= '0;
              state_r <= ST_PAYLOAD;
            end
          end else if (tmo_hit_s) begin
            state_r <= ST_HUNT;
          end
        end
        ST_PAYLOAD: begin
          // SOF bytes here are plain data; the length alone delimits the frame.
          if (accept_s) begin
            chk_acc_r <= chk_step(chk_acc_r, in_data);
            idx_r     <= idx_r + LEN_W'(1);
            if (idx_r == last_idx_s) begin
              state_r <= ST_CHK;
            end
          end else if (tmo_hit_s) begin
            state_r <= ST_HUNT;
          end
        end
        ST_CHK: begin
          if (accept_s) begin
            if (in_data == chk_acc_r) begin
              frame_len   <= LEN_W'(len_r);
              frame_valid <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              chk_err <= 1'b1;
              state_r <= ST_HUNT;
            end
          end else if (tmo_hit_s) begin
            state_r <= ST_HUNT;
          end
        end
        ST_DONE: begin
          if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
            state_r     <= ST_HUNT;
          end
        end
        default: begin
          frame_valid <= 1'b0;
          state_r     <= ST_HUNT;
        end
      endcase
    end
  end

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_we_s),
    .wr_addr (idx_r),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: byte-queue reference model checked on
// every falling edge, plus literal expectations for each scenario.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             frame_valid;
  logic             frame_ready = 1'b0;
  logic [LEN_W-1:0] frame_len;
  logic [LEN_W-1:0] rd_addr = '0;
  logic [7:0]       rd_data;
  logic             chk_err;
  logic             len_err;
  logic             tmo_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_len   (frame_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .chk_err     (chk_err),
    .len_err     (len_err),
    .tmo_err     (tmo_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes collected since the last SOF, judged by length/XOR.
  bit         m_held = 1'b0;
  bit         m_chk  = 1'b0;
  bit         m_len  = 1'b0;
  int         m_flen = 0;
  logic [7:0] m_coll[$];
  logic [7:0] m_pay[$];

  initial begin
    logic [7:0] x;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_held = 1'b0; m_chk = 1'b0; m_len = 1'b0; m_flen = 0;
        m_coll.delete(); m_pay.delete();
      end else begin
        m_chk = 1'b0;
        m_len = 1'b0;
        if (m_held) begin
          if (frame_ready) m_held = 1'b0;
        end else if (in_valid) begin
          if (m_coll.size() == 0) begin
            if (in_data == 8'hA5) m_coll.push_back(in_data);
          end else begin
            m_coll.push_back(in_data);
            if (m_coll.size() == 2 && int'(in_data) > MAX_LEN) begin
              m_len = 1'b1;
              m_coll.delete();
            end else if (m_coll.size() == int'(m_coll[1]) + 3) begin
              x = 8'h00;
              for (int i = 1; i < m_coll.size() - 1; i++) x = x ^ m_coll[i];
              if (x == in_data) begin
                m_held = 1'b1;
                m_flen = int'(m_coll[1]);
                m_pay.delete();
                for (int i = 2; i < m_coll.size() - 1; i++) m_pay.push_back(m_coll[i]);
              end else begin
                m_chk = 1'b1;
              end
              m_coll.delete();
            end
          end
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("in_ready", {31'd0, in_ready}, {31'd0, !m_held});
      check("frame_valid", {31'd0, frame_valid}, {31'd0, m_held});
      check("frame_len", 32'(frame_len), 32'(m_flen));
      check("chk_err", {31'd0, chk_err}, {31'd0, m_chk});
      check("len_err", {31'd0, len_err}, {31'd0, m_len});
      check("tmo_err", {31'd0, tmo_err}, 32'd0);
      if (m_held && (int'(rd_addr) < m_flen)) begin
        check("rd_data", {24'd0, rd_data}, {24'd0, m_pay[rd_addr]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input int n, input logic [63:0] v);
    int w;
    for (int i = 0; i < n; i++) begin
      in_data  = v[8*(n-1-i) +: 8];
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 300) begin
        step();
        w++;
      end
      if (w >= 300) check("in_ready_wait", 32'd0, 32'd1);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [LEN_W-1:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(name, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic release_frame();
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Good frame, then 100 cycles of back-pressure with a pending byte.
    send_bytes(6, 64'hA5_03_11_22_33_03);
    @(negedge clk);
    check("good_fv", {31'd0, frame_valid}, 32'd1);
    check("good_len", 32'(frame_len), 32'd3);
    read_expect("good_rd0", 5'd0, 8'h11);
    read_expect("good_rd1", 5'd1, 8'h22);
    read_expect("good_rd2", 5'd2, 8'h33);
    read_expect("rd_oob", 5'd20, 8'h00);
    in_data  = 8'hA5;
    in_valid = 1'b1;
    repeat (100) step();
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    release_frame();
    @(negedge clk);
    check("rel_fv", {31'd0, frame_valid}, 32'd0);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    send_bytes(3, 64'h01_44_45);
    @(negedge clk);
    check("bp_not_consumed", {31'd0, frame_valid}, 32'd0);

    // Bad checksum, then a zero-length frame.
    send_bytes(6, 64'hA5_03_11_22_33_00);
    @(negedge clk);
    check("bad_chk_pulse", {31'd0, chk_err}, 32'd1);
    check("bad_chk_nofv", {31'd0, frame_valid}, 32'd0);
    @(negedge clk);
    check("bad_chk_single", {31'd0, chk_err}, 32'd0);
    send_bytes(3, 64'hA5_00_00);
    @(negedge clk);
    check("len0_fv", {31'd0, frame_valid}, 32'd1);
    check("len0_len", 32'(frame_len), 32'd0);
    release_frame();

    // Garbage prefix and SOF bytes inside the payload.
    send_bytes(8, 64'h00_FF_5A_A5_02_A5_A5_00);
    @(negedge clk);
    check("garb_chk_err", {31'd0, chk_err}, 32'd1);
    send_bytes(5, 64'hA5_02_A5_A5_02);
    @(negedge clk);
    check("garb_len", 32'(frame_len), 32'd2);
    read_expect("garb_rd0", 5'd0, 8'hA5);
    read_expect("garb_rd1", 5'd1, 8'hA5);
    release_frame();

    // Length overflow, then a one-byte frame.
    send_bytes(2, 64'hA5_11);
    @(negedge clk);
    check("len_err_pulse", {31'd0, len_err}, 32'd1);
    send_bytes(4, 64'hA5_01_7E_7F);
    @(negedge clk);
    check("ovf_next_fv", {31'd0, frame_valid}, 32'd1);
    read_expect("ovf_next_rd0", 5'd0, 8'h7E);
    release_frame();

    // Long stall mid-frame: the frame must still complete when bytes resume.
    send_bytes(3, 64'hA5_04_AA);
    repeat (600) step();
    check("stall_no_tmo", {31'd0, tmo_err}, 32'd0);
    send_bytes(4, 64'hBB_CC_DD_04);
    @(negedge clk);
    check("stall_fv", {31'd0, frame_valid}, 32'd1);
    check("stall_len", 32'(frame_len), 32'd4);
    read_expect("stall_rd3", 5'd3, 8'hDD);
    release_frame();

    // Reset in the middle of a frame.
    send_bytes(3, 64'hA5_04_AA);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_len", 32'(frame_len), 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    step();
    send_bytes(4, 64'hA5_01_55_54);
    @(negedge clk);
    check("post_rst_fv", {31'd0, frame_valid}, 32'd1);
    read_expect("post_rst_rd0", 5'd0, 8'h55);
    release_frame();

    // Bad frame immediately followed by a good one on consecutive bytes.
    send_bytes(8, 64'hA5_01_10_00_A5_01_20_21);
    @(negedge clk);
    check("b2b_fv", {31'd0, frame_valid}, 32'd1);
    read_expect("b2b_rd0", 5'd0, 8'h20);
    release_frame();

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
